// File: rtl/block_stream_loader.sv
// Block stream loader: gathers eight operand words for a 2x2 multiplier,
// launches it, then streams the four result words back out.
module block_stream_loader #(
    parameter int WAIT_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] mm_a,
    output logic [127:0] mm_b,
    output logic         mm_start,
    input  logic         mm_done,
    input  logic [127:0] mm_c,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         err_timeout
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [15:0] LIM_LAST = 16'(WAIT_LIMIT - 1);

    state_t      state;
    logic [2:0]  wcnt;
    logic [1:0]  ocnt;
    logic [15:0] wait_cnt;
    logic [31:0] opw [8];
    logic [31:0] res [4];

    assign mm_a = {opw[0], opw[1], opw[2], opw[3]};
    assign mm_b = {opw[4], opw[5], opw[6], opw[7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_LOAD;
            wcnt        <= '0;
            ocnt        <= '0;
            wait_cnt    <= '0;
            for (int i = 0; i < 8; i++) opw[i] <= '0;
            for (int i = 0; i < 4; i++) res[i] <= '0;
            in_ready    <= 1'b0;
            mm_start    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            mm_start <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        opw[wcnt] <= in_data;
                        wcnt      <= wcnt + 3'd1;
                        if (wcnt == 3'd7) begin
                            state    <= S_START;
                            mm_start <= 1'b1;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    // A completion arriving on the last allowed cycle still wins
                    if (mm_done) begin
                        res[0]    <= mm_c[127:96];
                        res[1]    <= mm_c[95:64];
                        res[2]    <= mm_c[63:32];
                        res[3]    <= mm_c[31:0];
                        out_data  <= mm_c[127:96];
                        out_valid <= 1'b1;
                        ocnt      <= '0;
                        state     <= S_DRAIN;
                    end else if (wait_cnt == LIM_LAST) begin
                        for (int i = 0; i < 4; i++) res[i] <= QNAN;
                        out_data    <= QNAN;
                        out_valid   <= 1'b1;
                        ocnt        <= '0;
                        err_timeout <= 1'b1;
                        state       <= S_DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (ocnt == 2'd3) begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            ocnt      <= '0;
                            state     <= S_LOAD;
                        end else begin
                            ocnt     <= ocnt + 2'd1;
                            out_data <= res[ocnt + 2'd1];
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_block_stream_loader.sv
// Directed bench for block_stream_loader: load, launch, respond, drain,
// timeout, spurious completions and mid-transaction reset.
module tb_block_stream_loader;

    localparam int WL = 16;

    localparam logic [127:0] A_M  = 128'h3F800000_40000000_40400000_40800000;
    localparam logic [127:0] I_M  = 128'h3F800000_00000000_00000000_3F800000;
    localparam logic [127:0] A2   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] B2   = 128'h80000000_7F800000_00000001_FFFFFFFF;
    localparam logic [127:0] C2   = 128'hC0490FDB_3DCCCCCD_FF800000_00000000;
    localparam logic [127:0] NAN4 = {4{32'h7FC00000}};
    localparam logic [127:0] JUNK = 128'hDEADBEEF_CAFEF00D_BAADF00D_0BADC0DE;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] mm_a;
    logic [127:0] mm_b;
    logic         mm_start;
    logic         mm_done;
    logic [127:0] mm_c;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    block_stream_loader #(.WAIT_LIMIT(WL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mm_a       (mm_a),
        .mm_b       (mm_b),
        .mm_start   (mm_start),
        .mm_done    (mm_done),
        .mm_c       (mm_c),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        chk("push_ready_timeout", 128'(guard < 20), 128'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Ends in the cycle where mm_start is expected high.
    task automatic load8(input logic [127:0] a, input logic [127:0] b,
                         input bit gap);
        logic [255:0] w;
        w = {a, b};
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                in_valid = 1'b0;
                tick();
            end
            if (i == 7) chk("start_early", 128'(mm_start), 128'd0);
            push(w[255:224]);
            w = w << 32;
        end
        chk("start_pulse_hi", 128'(mm_start), 128'd1);
        chk("mm_a", mm_a, a);
        chk("mm_b", mm_b, b);
        chk("in_ready_start", 128'(in_ready), 128'd0);
        chk("busy_start", 128'(busy), 128'd1);
    endtask

    // mm_done raised in the k-th S_WAIT cycle.
    task automatic respond(input int k, input logic [127:0] c);
        tick();
        chk("start_pulse_lo", 128'(mm_start), 128'd0);
        repeat (k - 1) tick();
        chk("out_valid_wait", 128'(out_valid), 128'd0);
        mm_done = 1'b1;
        mm_c    = c;
        tick();
        mm_done = 1'b0;
        mm_c    = '0;
        chk("out_valid_rise", 128'(out_valid), 128'd1);
    endtask

    task automatic drain(input logic [127:0] exp, input int n,
                         input int stall_idx, input int stall_n,
                         input bit spur);
        logic [127:0] e;
        logic [31:0]  w;
        e = exp;
        for (int i = 0; i < n; i++) begin
            w = e[127:96];
            chk("out_valid", 128'(out_valid), 128'd1);
            chk("out_data", 128'(out_data), 128'(w));
            if (i == stall_idx) begin
                out_ready = 1'b0;
                if (spur) begin
                    mm_done = 1'b1;
                    mm_c    = JUNK;
                end
                repeat (stall_n) begin
                    tick();
                    chk("hold_data", 128'(out_data), 128'(w));
                    chk("hold_valid", 128'(out_valid), 128'd1);
                end
                mm_done = 1'b0;
                mm_c    = '0;
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            e = e << 32;
        end
        if (n == 4) begin
            chk("drain_end_valid", 128'(out_valid), 128'd0);
            chk("drain_end_ready", 128'(in_ready), 128'd1);
            chk("drain_end_busy", 128'(busy), 128'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        mm_done   = 1'b0;
        mm_c      = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_err", 128'(err_timeout), 128'd0);
        chk("rst_mm_start", 128'(mm_start), 128'd0);
        chk("rst_mm_a", mm_a, 128'd0);
        chk("rst_out_data", 128'(out_data), 128'd0);
        tick();
        tick();
        rst = 1'b0;
        chk("rel_in_ready_lo", 128'(in_ready), 128'd0);
        tick();
        chk("rel_in_ready_hi", 128'(in_ready), 128'd1);

        // Spurious completion while loading, then A x I with a stalled c12
        mm_done = 1'b1;
        mm_c    = JUNK;
        tick();
        tick();
        mm_done = 1'b0;
        mm_c    = '0;
        chk("spur_load_busy", 128'(busy), 128'd0);
        chk("spur_load_valid", 128'(out_valid), 128'd0);
        chk("spur_load_ready", 128'(in_ready), 128'd1);
        load8(A_M, I_M, 1'b0);
        respond(5, A_M);
        drain(A_M, 4, 1, 3, 1'b0);
        chk("mm_a_stable", mm_a, A_M);

        // Gapped load, completion on the last allowed cycle, spurious done in drain
        load8(A2, B2, 1'b1);
        respond(WL, C2);
        drain(C2, 4, 2, 2, 1'b1);
        chk("no_timeout", 128'(err_timeout), 128'd0);

        // Timeout
        load8(A_M, I_M, 1'b0);
        repeat (WL) tick();
        chk("to_valid_lo", 128'(out_valid), 128'd0);
        chk("to_busy", 128'(busy), 128'd1);
        tick();
        chk("to_err", 128'(err_timeout), 128'd1);
        drain(NAN4, 4, 4, 0, 1'b0);

        // Normal run after timeout, then reset after two drained words
        load8(A2, B2, 1'b0);
        respond(1, C2);
        drain(C2, 2, 4, 0, 1'b0);
        chk("err_sticky", 128'(err_timeout), 128'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_err", 128'(err_timeout), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_ready", 128'(in_ready), 128'd0);
        chk("mid_rst_data", 128'(out_data), 128'd0);
        chk("mid_rst_mm_a", mm_a, 128'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 128'(in_ready), 128'd1);

        // Fresh load after reset
        load8(A_M, I_M, 1'b1);
        respond(3, I_M);
        drain(I_M, 4, 0, 1, 1'b0);
        chk("final_err", 128'(err_timeout), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
